// File: rtl/snd_dma_arbiter.sv
// snd_dma_arbiter: multi-channel sound DMA frame controller granting one requesting channel per bus slot; ports clk32/reset/slot_en, per-channel ch_on/ch_rep/ch_req/ch_start/ch_end in, ch_addr/ch_frame/ch_int/ch_stoff and dma_load/dma_addr/dma_ch out; define SNDDMA_RR_EN for round-robin (default fixed priority, lowest index wins)
module snd_dma_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = 21,
  parameter int CW  = 3
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic              slot_en,
  input  logic [NCH-1:0]    ch_on,
  input  logic [NCH-1:0]    ch_rep,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*AW-1:0] ch_start,
  input  logic [NCH*AW-1:0] ch_end,
  output logic [NCH*AW-1:0] ch_addr,
  output logic [NCH-1:0]    ch_frame,
  output logic [NCH-1:0]    ch_int,
  output logic [NCH-1:0]    ch_stoff,
  output logic              dma_load,
  output logic [AW-1:0]     dma_addr,
  output logic [CW-1:0]     dma_ch
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st_q [NCH];
  state_t st_d [NCH];
  logic [AW-1:0] cnt_q [NCH];
  logic [AW-1:0] cnt_d [NCH];
  logic [AW-1:0] end_q [NCH];
  logic [AW-1:0] end_d [NCH];
  logic [NCH-1:0] int_q, int_d, stoff_q, stoff_d, elig, empty, hit;
  logic load_q, gnt;
  logic [AW-1:0] addr_q, gaddr;
  logic [CW-1:0] ch_q, gidx;
  int base;
`ifdef SNDDMA_RR_EN
  logic [CW-1:0] last_q;
`endif
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // counter only meets the latched end when the frame was empty on entry/reload
      empty[i] = cnt_q[i] == end_q[i];
      elig[i]  = slot_en && st_q[i] == RUN && ch_on[i] && ch_req[i] && !empty[i];
    end
  end
  always_comb begin
`ifdef SNDDMA_RR_EN
    base = int'(last_q) + 1;
`else
    base = 0;
`endif
    gnt   = 1'b0;
    gidx  = '0;
    gaddr = '0;
    hit   = '0;
    for (int k = 0; k < NCH; k++)
      for (int j = 0; j < NCH; j++)
        if (!gnt && j == (base + k) % NCH && elig[j]) begin
          gnt    = 1'b1;
          gidx   = CW'(j);
          gaddr  = cnt_q[j];
          hit[j] = 1'b1;
        end
  end
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      st_d[i]    = st_q[i];
      cnt_d[i]   = cnt_q[i];
      end_d[i]   = end_q[i];
      int_d[i]   = 1'b0;
      stoff_d[i] = 1'b0;
      case (st_q[i])
        IDLE: if (ch_on[i]) begin
          st_d[i]  = RUN;
          cnt_d[i] = ch_start[i*AW +: AW];
          end_d[i] = ch_end[i*AW +: AW];
        end
        RUN: if (!ch_on[i]) st_d[i] = IDLE;
        else if (empty[i] || (hit[i] && (cnt_q[i] + AW'(1)) == end_q[i])) begin
          int_d[i]   = 1'b1;
          cnt_d[i]   = ch_start[i*AW +: AW];
          end_d[i]   = ch_rep[i] ? ch_end[i*AW +: AW] : end_q[i];
          st_d[i]    = ch_rep[i] ? RUN : DONE;
          stoff_d[i] = !ch_rep[i];
        end
        else if (hit[i]) cnt_d[i] = cnt_q[i] + AW'(1);
        default: if (!ch_on[i]) st_d[i] = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk32) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
        end_q[i] <= '0;
      end
      int_q   <= '0;
      stoff_q <= '0;
      load_q  <= 1'b0;
      addr_q  <= '0;
      ch_q    <= '0;
`ifdef SNDDMA_RR_EN
      last_q  <= CW'(NCH - 1);
`endif
    end else begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        end_q[i] <= end_d[i];
      end
      int_q   <= int_d;
      stoff_q <= stoff_d;
      load_q  <= gnt;
      addr_q  <= gnt ? gaddr : addr_q;
      ch_q    <= gnt ? gidx : ch_q;
`ifdef SNDDMA_RR_EN
      last_q  <= gnt ? gidx : last_q;
`endif
    end
  end
  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign ch_addr[g*AW +: AW] = cnt_q[g];
    assign ch_frame[g]         = st_q[g] == RUN;
  end
  assign ch_int   = int_q;
  assign ch_stoff = stoff_q;
  assign dma_load = load_q;
  assign dma_addr = addr_q;
  assign dma_ch   = ch_q;
endmodule

// File: tb/tb_snd_dma_arbiter.sv
// tb_snd_dma_arbiter: scoreboard bench for snd_dma_arbiter with directed frame scenarios
module tb_snd_dma_arbiter;
  localparam int NCH = 2, AW = 21, CW = 3;
  logic clk32 = 1'b0, reset = 1'b1, slot_en = 1'b0;
  logic [NCH-1:0] ch_on = '0, ch_rep = '0, ch_req = '0;
  logic [NCH*AW-1:0] ch_start = '0, ch_end = '0;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0] ch_frame, ch_int, ch_stoff;
  logic dma_load;
  logic [AW-1:0] dma_addr;
  logic [CW-1:0] dma_ch;
  typedef struct packed {logic [CW-1:0] ch; logic [AW-1:0] addr;} ld_t;
  typedef struct packed {logic [CW-1:0] ch; logic stoff;} in_t;
  ld_t ld_q[$];
  in_t in_q[$];
  int pass_n = 0, total_n = 0;
  snd_dma_arbiter #(.NCH(NCH), .AW(AW), .CW(CW)) dut (
    .clk32(clk32), .reset(reset), .slot_en(slot_en), .ch_on(ch_on), .ch_rep(ch_rep),
    .ch_req(ch_req), .ch_start(ch_start), .ch_end(ch_end), .ch_addr(ch_addr),
    .ch_frame(ch_frame), .ch_int(ch_int), .ch_stoff(ch_stoff), .dma_load(dma_load),
    .dma_addr(dma_addr), .dma_ch(dma_ch)
  );
  always #5 clk32 = ~clk32;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  always @(negedge clk32) begin
    ld_t e;
    in_t f;
    if (!reset) begin
      if (dma_load) begin
        if (ld_q.size() == 0) chk("load_expected", ld_q.size(), 1);
        else begin
          e = ld_q.pop_front();
          chk("dma_ch", 32'(dma_ch), 32'(e.ch));
          chk("dma_addr", 32'(dma_addr), 32'(e.addr));
        end
      end
      for (int i = 0; i < NCH; i++)
        if (ch_int[i]) begin
          if (in_q.size() == 0) chk("int_expected", in_q.size(), 1);
          else begin
            f = in_q.pop_front();
            chk("int_ch", i, 32'(f.ch));
            chk("int_stoff", 32'(ch_stoff[i]), 32'(f.stoff));
          end
        end
        else if (ch_stoff[i]) chk("stoff_without_int", 32'(ch_stoff[i]), 0);
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk32);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask
  task automatic slot(input int n);
    repeat (n) begin
      slot_en = 1'b1;
      tick(1);
      slot_en = 1'b0;
      tick(3);
    end
  endtask
  task automatic set_ch(input int i, input logic [AW-1:0] s, input logic [AW-1:0] e);
    ch_start[i*AW +: AW] = s;
    ch_end[i*AW +: AW]   = e;
  endtask
  task automatic push_ld(input int c, input logic [AW-1:0] a);
    ld_q.push_back('{ch: CW'(c), addr: a});
  endtask
  task automatic push_in(input int c, input logic s);
    in_q.push_back('{ch: CW'(c), stoff: s});
  endtask
  task automatic check_zero(input string tag);
    @(negedge clk32);
    chk({tag, "_ch_addr"}, 32'(|ch_addr), 0);
    chk({tag, "_flags"}, 32'({ch_frame, ch_int, ch_stoff, dma_load}), 0);
    chk({tag, "_dma"}, 32'({dma_ch, dma_addr}), 0);
  endtask
  initial begin
    do_reset();
    check_zero("reset");
    // single non-repeat frame
    do_reset();
    set_ch(0, 21'h100, 21'h104);
    ch_req = 2'b01;
    for (int a = 'h100; a < 'h104; a++) push_ld(0, AW'(a));
    push_in(0, 1'b1);
    ch_on = 2'b01;
    tick(1);
    slot(4);
    slot(2);
    @(negedge clk32);
    chk("t1_frame", 32'(ch_frame), 0);
    chk("t1_hold_addr", 32'(dma_addr), 32'h103);
    chk("t1_hold_ch", 32'(dma_ch), 0);
    ch_on = '0;
    tick(1);
    // repeat with start/end rewritten mid-frame
    do_reset();
    set_ch(0, 21'h100, 21'h104);
    ch_rep = 2'b01;
    for (int a = 'h100; a < 'h104; a++) push_ld(0, AW'(a));
    push_in(0, 1'b0);
    for (int a = 'h200; a < 'h204; a++) push_ld(0, AW'(a));
    push_in(0, 1'b0);
    ch_on = 2'b01;
    tick(1);
    slot(1);
    set_ch(0, 21'h200, 21'h204);
    slot(3);
    @(negedge clk32);
    chk("t2_frame_mid", 32'(ch_frame), 1);
    tick(0);
    slot(4);
    @(negedge clk32);
    chk("t2_frame_end", 32'(ch_frame), 1);
    chk("t2_reload", 32'(ch_addr[AW-1:0]), 32'h200);
    ch_on = '0;
    ch_rep = '0;
    tick(1);
    @(negedge clk32);
    chk("t2_off", 32'(ch_frame), 0);
    // two requesters
    do_reset();
    set_ch(0, 21'h400, 21'h500);
    set_ch(1, 21'h600, 21'h700);
    ch_req = 2'b11;
`ifdef SNDDMA_RR_EN
    for (int n = 0; n < 3; n++) begin
      push_ld(0, AW'('h400 + n));
      push_ld(1, AW'('h600 + n));
    end
`else
    for (int n = 0; n < 6; n++) push_ld(0, AW'('h400 + n));
`endif
    ch_on = 2'b11;
    tick(1);
    slot(6);
    ch_on = '0;
    tick(1);
    // address wrap through zero
    do_reset();
    set_ch(0, 21'h1FFFFF, 21'h000001);
    ch_req = 2'b01;
    push_ld(0, 21'h1FFFFF);
    push_ld(0, 21'h000000);
    push_in(0, 1'b1);
    ch_on = 2'b01;
    tick(1);
    slot(3);
    @(negedge clk32);
    chk("t4_frame", 32'(ch_frame), 0);
    ch_on = '0;
    tick(1);
    // empty frame
    do_reset();
    set_ch(0, 21'h300, 21'h300);
    push_in(0, 1'b1);
    ch_on = 2'b01;
    slot_en = 1'b1;
    tick(1);
    @(negedge clk32);
    chk("t5_run", 32'(ch_frame), 1);
    chk("t5_int_early", 32'(ch_int), 0);
    tick(0);
    tick(1);
    @(negedge clk32);
    chk("t5_int", 32'({ch_int, ch_stoff}), 32'b0101);
    chk("t5_frame", 32'(ch_frame), 0);
    chk("t5_noload", 32'(dma_load), 0);
    slot_en = 1'b0;
    ch_on = '0;
    tick(2);
    // disable on slot, then reset mid-frame
    do_reset();
    set_ch(0, 21'h800, 21'h900);
    set_ch(1, 21'hA00, 21'hB00);
    ch_req = 2'b01;
    push_ld(0, 21'h800);
    ch_on = 2'b11;
    tick(1);
    slot(1);
    ch_on[0] = 1'b0;
    slot_en = 1'b1;
    tick(1);
    slot_en = 1'b0;
    @(negedge clk32);
    chk("t6_frame", 32'(ch_frame), 32'b10);
    chk("t6_noload", 32'(dma_load), 0);
    tick(0);
    tick(2);
    ch_req = 2'b11;
    push_ld(1, 21'hA00);
    slot(1);
    reset = 1'b1;
    ch_on = '0;
    tick(1);
    check_zero("t6_reset");
    tick(0);
    reset = 1'b0;
    tick(4);
    chk("ld_q_empty", ld_q.size(), 0);
    chk("in_q_empty", in_q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
